// File: rtl/change_hopper_controller_if.sv
// Signal bundle between the soda machine credit logic / hopper hardware and
// the change hopper controller.
interface change_hopper_controller_if #(
    parameter int CNT_W   = 5,
    parameter int STOCK_W = 8
);
    // Request handshake: a request transfers on a rising clock edge where
    // req_valid and req_ready are both 1. req_coins must be stable while
    // req_valid is 1. A request offered while req_ready is 0 is dropped.
    logic               req_valid;
    logic               req_ready;
    logic [CNT_W-1:0]   req_coins;

    logic               refill_valid;
    logic [CNT_W-1:0]   refill_coins;
    logic               coin_sensed;

    logic               pop_100_yen_coin;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   paid_coins;
    logic               short_change;
    logic               fault;
    logic [STOCK_W-1:0] stock_level;
    logic               stock_low;
    logic [2:0]         dbg_state;

    modport master (
        output req_valid, req_coins, refill_valid, refill_coins, coin_sensed,
        input  req_ready, pop_100_yen_coin, busy, done, paid_coins,
               short_change, fault, stock_level, stock_low, dbg_state
    );

    modport slave (
        input  req_valid, req_coins, refill_valid, refill_coins, coin_sensed,
        output req_ready, pop_100_yen_coin, busy, done, paid_coins,
               short_change, fault, stock_level, stock_low, dbg_state
    );
endinterface

// File: rtl/change_hopper_controller.sv
// 100-yen change hopper sequencer: ejects requested coins one at a time,
// confirms each with the exit sensor, retries missing coins, tracks stock.
module change_hopper_controller #(
    parameter int CNT_W          = 5,
    parameter int STOCK_W        = 8,
    parameter int STOCK_INIT     = 50,
    parameter int LOW_WATER      = 5,
    parameter int EJECT_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int MAX_RETRIES    = 2
) (
    input logic                  clock,
    input logic                  reset,
    change_hopper_controller_if.slave hif
);
    localparam int ECW  = $clog2(EJECT_CYCLES + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int XW   = STOCK_W + CNT_W;
    localparam int SUMW = XW + 1;

    localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
    localparam logic [ECW-1:0]     EJECT_END = ECW'(EJECT_CYCLES - 1);
    localparam logic [TW-1:0]      TIME_END  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]      RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [SUMW-1:0]    STOCK_MAX = SUMW'((1 << STOCK_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EJECT      = 3'd1,
        S_WAIT_SENSE = 3'd2,
        S_DONE       = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [STOCK_W-1:0] stock;
    logic [CNT_W-1:0]   paid;
    logic [CNT_W-1:0]   target;
    logic               short_q;
    logic [ECW-1:0]     eject_cnt;
    logic [TW-1:0]      timer;
    logic [RW-1:0]      retries;
    logic               sensed_flag;

    logic               accept;
    logic               count_coin;
    logic               retry_inc;
    logic               eject_last;
    logic               short_n;
    logic [CNT_W-1:0]   target_n;
    logic [CNT_W-1:0]   paid_plus;
    logic [SUMW-1:0]    stock_sum;
    logic [STOCK_W-1:0] stock_n;

    always_comb begin
        short_n  = XW'(hif.req_coins) > XW'(stock);
        // When short, stock is below req_coins and therefore fits in CNT_W.
        target_n = short_n ? CNT_W'(stock) : hif.req_coins;
    end

    assign paid_plus  = paid + ONE_C;
    assign eject_last = (eject_cnt == EJECT_END);

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        count_coin = 1'b0;
        retry_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (hif.req_valid) begin
                    accept  = 1'b1;
                    state_n = (target_n == '0) ? S_DONE : S_EJECT;
                end
            end
            S_EJECT: begin
                // A coin seen mid-pulse is counted once; the pulse still completes.
                if (hif.coin_sensed && !sensed_flag) begin
                    count_coin = 1'b1;
                end
                if (eject_last) begin
                    if (sensed_flag) begin
                        state_n = (paid == target) ? S_DONE : S_EJECT;
                    end else if (count_coin) begin
                        state_n = (paid_plus == target) ? S_DONE : S_EJECT;
                    end else begin
                        state_n = S_WAIT_SENSE;
                    end
                end
            end
            S_WAIT_SENSE: begin
                if (hif.coin_sensed) begin
                    count_coin = 1'b1;
                    state_n    = (paid_plus == target) ? S_DONE : S_EJECT;
                end else if (timer == TIME_END) begin
                    if (retries == RETRY_MAX) begin
                        state_n = S_FAULT;
                    end else begin
                        retry_inc = 1'b1;
                        state_n   = S_EJECT;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Refill and a same-cycle sensor decrement net out before saturating.
    always_comb begin
        stock_sum = SUMW'(stock)
                  + (hif.refill_valid ? SUMW'(hif.refill_coins) : '0)
                  - SUMW'(count_coin);
        stock_n   = (stock_sum > STOCK_MAX) ? STOCK_W'(STOCK_MAX) : STOCK_W'(stock_sum);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stock       <= STOCK_W'(STOCK_INIT);
            paid        <= '0;
            target      <= '0;
            short_q     <= 1'b0;
            eject_cnt   <= '0;
            timer       <= '0;
            retries     <= '0;
            sensed_flag <= 1'b0;
        end else begin
            stock <= stock_n;

            if (accept) begin
                paid    <= '0;
                target  <= target_n;
                short_q <= short_n;
                retries <= '0;
            end else if (count_coin) begin
                paid    <= paid_plus;
                retries <= '0;
            end else if (retry_inc) begin
                retries <= retries + RW'(1);
            end

            if (state == S_EJECT && !eject_last) begin
                eject_cnt   <= eject_cnt + ECW'(1);
                sensed_flag <= sensed_flag | count_coin;
            end else begin
                eject_cnt   <= '0;
                sensed_flag <= 1'b0;
            end

            if (state == S_WAIT_SENSE && state_n == S_WAIT_SENSE) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    assign hif.req_ready        = (state == S_IDLE);
    assign hif.pop_100_yen_coin = (state == S_EJECT);
    assign hif.busy             = (state != S_IDLE);
    assign hif.done             = (state == S_DONE);
    assign hif.fault            = (state == S_FAULT);
    assign hif.paid_coins       = paid;
    assign hif.short_change     = short_q;
    assign hif.stock_level      = stock;
    assign hif.stock_low        = (stock < STOCK_W'(LOW_WATER));
    assign hif.dbg_state        = state;
endmodule

// File: tb/tb_change_hopper_controller.sv
// Directed bench for change_hopper_controller: payout, zero request, short
// change, sensor/refill netting, saturation, retry, fault and mid-run reset.
module tb_change_hopper_controller;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    change_hopper_controller_if hif ();

    change_hopper_controller dut (
        .clock (clock),
        .reset (reset),
        .hif   (hif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [4:0] n);
        hif.req_valid = 1'b1;
        hif.req_coins = n;
        step();
        hif.req_valid = 1'b0;
        hif.req_coins = '0;
    endtask

    task automatic refill(input logic [4:0] n);
        hif.refill_valid = 1'b1;
        hif.refill_coins = n;
        step();
        hif.refill_valid = 1'b0;
        hif.refill_coins = '0;
    endtask

    // Counts the current eject pulse, then confirms the coin one cycle later.
    task automatic serve_coin(input logic [4:0] rf, output int len);
        len = 0;
        for (int k = 0; k < 20 && hif.pop_100_yen_coin === 1'b1; k++) begin
            len++;
            step();
        end
        hif.coin_sensed  = 1'b1;
        hif.refill_valid = (rf != 0);
        hif.refill_coins = rf;
        step();
        hif.coin_sensed  = 1'b0;
        hif.refill_valid = 1'b0;
        hif.refill_coins = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        hif.req_valid = 1'b0; hif.req_coins = '0;
        hif.refill_valid = 1'b0; hif.refill_coins = '0;
        hif.coin_sensed = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        n_checks++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", hif.busy); end
        n_checks++; if (hif.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", hif.req_ready); end
        n_checks++; if (hif.pop_100_yen_coin !== 1'b0) begin n_fail++; $display("FAIL reset_pop got %0b want 0", hif.pop_100_yen_coin); end
        n_checks++; if (hif.done !== 1'b0 || hif.fault !== 1'b0 || hif.short_change !== 1'b0) begin n_fail++; $display("FAIL reset_flags got done=%0b fault=%0b short=%0b want 0", hif.done, hif.fault, hif.short_change); end
        n_checks++; if (hif.stock_level !== 8'd50) begin n_fail++; $display("FAIL reset_stock got %0d want 50", hif.stock_level); end
        n_checks++; if (hif.paid_coins !== 5'd0 || hif.stock_low !== 1'b0) begin n_fail++; $display("FAIL reset_paid_low got paid=%0d low=%0b want 0/0", hif.paid_coins, hif.stock_low); end
    endtask

    task automatic test_basic();
        int len;
        request(5'd4);
        for (int i = 0; i < 4; i++) begin
            serve_coin(5'd0, len);
            n_checks++; if (len != 2) begin n_fail++; $display("FAIL basic_pulse_len coin %0d got %0d want 2", i, len); end
        end
        n_checks++; if (hif.done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %0b want 1", hif.done); end
        n_checks++; if (hif.paid_coins !== 5'd4) begin n_fail++; $display("FAIL basic_paid got %0d want 4", hif.paid_coins); end
        n_checks++; if (hif.short_change !== 1'b0) begin n_fail++; $display("FAIL basic_short got %0b want 0", hif.short_change); end
        n_checks++; if (hif.stock_level !== 8'd46) begin n_fail++; $display("FAIL basic_stock got %0d want 46", hif.stock_level); end
        step();
        n_checks++; if (hif.done !== 1'b0 || hif.busy !== 1'b0 || hif.req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle got done=%0b busy=%0b ready=%0b want 0/0/1", hif.done, hif.busy, hif.req_ready); end
    endtask

    task automatic test_zero();
        request(5'd0);
        n_checks++; if (hif.done !== 1'b1 || hif.busy !== 1'b1) begin n_fail++; $display("FAIL zero_done got done=%0b busy=%0b want 1/1", hif.done, hif.busy); end
        n_checks++; if (hif.pop_100_yen_coin !== 1'b0 || hif.paid_coins !== 5'd0) begin n_fail++; $display("FAIL zero_nopop got pop=%0b paid=%0d want 0/0", hif.pop_100_yen_coin, hif.paid_coins); end
        step();
        n_checks++; if (hif.busy !== 1'b0 || hif.done !== 1'b0) begin n_fail++; $display("FAIL zero_idle got busy=%0b done=%0b want 0/0", hif.busy, hif.done); end
    endtask

    task automatic test_refill_with_sense();
        int len;
        request(5'd1);
        serve_coin(5'd10, len);
        n_checks++; if (len != 2 || hif.done !== 1'b1) begin n_fail++; $display("FAIL net_done got len=%0d done=%0b want 2/1", len, hif.done); end
        n_checks++; if (hif.stock_level !== 8'd55) begin n_fail++; $display("FAIL net_stock got %0d want 55", hif.stock_level); end
        step();
    endtask

    task automatic test_short();
        int len;
        request(5'd31);
        for (int i = 0; i < 31; i++) serve_coin(5'd0, len);
        n_checks++; if (hif.done !== 1'b1 || hif.paid_coins !== 5'd31) begin n_fail++; $display("FAIL drain31 got done=%0b paid=%0d want 1/31", hif.done, hif.paid_coins); end
        step();
        request(5'd21);
        for (int i = 0; i < 21; i++) serve_coin(5'd0, len);
        step();
        n_checks++; if (hif.stock_level !== 8'd3 || hif.stock_low !== 1'b1) begin n_fail++; $display("FAIL drain_stock got %0d low=%0b want 3/1", hif.stock_level, hif.stock_low); end
        request(5'd5);
        for (int i = 0; i < 3; i++) begin
            serve_coin(5'd0, len);
            n_checks++; if (len != 2) begin n_fail++; $display("FAIL short_pulse_len coin %0d got %0d want 2", i, len); end
        end
        n_checks++; if (hif.done !== 1'b1 || hif.paid_coins !== 5'd3) begin n_fail++; $display("FAIL short_done got done=%0b paid=%0d want 1/3", hif.done, hif.paid_coins); end
        n_checks++; if (hif.short_change !== 1'b1) begin n_fail++; $display("FAIL short_flag got %0b want 1", hif.short_change); end
        n_checks++; if (hif.stock_level !== 8'd0 || hif.stock_low !== 1'b1) begin n_fail++; $display("FAIL short_stock got %0d low=%0b want 0/1", hif.stock_level, hif.stock_low); end
        step();
        n_checks++; if (hif.short_change !== 1'b1 || hif.busy !== 1'b0) begin n_fail++; $display("FAIL short_hold got short=%0b busy=%0b want 1/0", hif.short_change, hif.busy); end
    endtask

    task automatic test_refill_sat();
        for (int i = 0; i < 8; i++) refill(5'd31);
        n_checks++; if (hif.stock_level !== 8'd248 || hif.stock_low !== 1'b0) begin n_fail++; $display("FAIL refill_248 got %0d low=%0b want 248/0", hif.stock_level, hif.stock_low); end
        refill(5'd2);
        n_checks++; if (hif.stock_level !== 8'd250) begin n_fail++; $display("FAIL refill_250 got %0d want 250", hif.stock_level); end
        refill(5'd10);
        n_checks++; if (hif.stock_level !== 8'd255) begin n_fail++; $display("FAIL refill_sat got %0d want 255", hif.stock_level); end
        refill(5'd31);
        n_checks++; if (hif.stock_level !== 8'd255) begin n_fail++; $display("FAIL refill_sat_hold got %0d want 255", hif.stock_level); end
        hif.coin_sensed = 1'b1;
        step();
        hif.coin_sensed = 1'b0;
        n_checks++; if (hif.stock_level !== 8'd255 || hif.paid_coins !== 5'd3) begin n_fail++; $display("FAIL idle_sense got stock=%0d paid=%0d want 255/3", hif.stock_level, hif.paid_coins); end
    endtask

    task automatic test_sense_in_eject();
        int len;
        request(5'd2);
        hif.coin_sensed = 1'b1;
        step();
        hif.coin_sensed = 1'b0;
        n_checks++; if (hif.paid_coins !== 5'd1 || hif.stock_level !== 8'd254 || hif.pop_100_yen_coin !== 1'b1) begin n_fail++; $display("FAIL eject_sense got paid=%0d stock=%0d pop=%0b want 1/254/1", hif.paid_coins, hif.stock_level, hif.pop_100_yen_coin); end
        step();
        n_checks++; if (hif.pop_100_yen_coin !== 1'b1 || hif.paid_coins !== 5'd1) begin n_fail++; $display("FAIL eject_no_wait got pop=%0b paid=%0d want 1/1", hif.pop_100_yen_coin, hif.paid_coins); end
        serve_coin(5'd0, len);
        n_checks++; if (len != 2 || hif.done !== 1'b1 || hif.paid_coins !== 5'd2) begin n_fail++; $display("FAIL eject_done got len=%0d done=%0b paid=%0d want 2/1/2", len, hif.done, hif.paid_coins); end
        n_checks++; if (hif.stock_level !== 8'd253 || hif.short_change !== 1'b0) begin n_fail++; $display("FAIL eject_stock got %0d short=%0b want 253/0", hif.stock_level, hif.short_change); end
        step();
    endtask

    task automatic test_retry();
        int len;
        request(5'd1);
        repeat (2) step();
        repeat (7) step();
        n_checks++; if (hif.pop_100_yen_coin !== 1'b0 || hif.busy !== 1'b1) begin n_fail++; $display("FAIL retry_wait got pop=%0b busy=%0b want 0/1", hif.pop_100_yen_coin, hif.busy); end
        step();
        n_checks++; if (hif.pop_100_yen_coin !== 1'b1) begin n_fail++; $display("FAIL retry_pop got %0b want 1", hif.pop_100_yen_coin); end
        serve_coin(5'd0, len);
        n_checks++; if (len != 2 || hif.done !== 1'b1 || hif.paid_coins !== 5'd1 || hif.stock_level !== 8'd252) begin n_fail++; $display("FAIL retry_done got len=%0d done=%0b paid=%0d stock=%0d want 2/1/1/252", len, hif.done, hif.paid_coins, hif.stock_level); end
        step();
    endtask

    task automatic test_fault();
        int starts[3];
        int npulse;
        int pop_total;
        int fault_at;
        logic prev_pop;
        logic any_pop;
        npulse = 0; pop_total = 0; fault_at = -1; prev_pop = 1'b0;
        starts[0] = -1; starts[1] = -1; starts[2] = -1;
        request(5'd1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (hif.pop_100_yen_coin === 1'b1 && !prev_pop) begin
                if (npulse < 3) starts[npulse] = cyc;
                npulse++;
            end
            if (hif.pop_100_yen_coin === 1'b1) pop_total++;
            if (hif.fault === 1'b1 && fault_at < 0) fault_at = cyc;
            prev_pop = (hif.pop_100_yen_coin === 1'b1);
            step();
        end
        n_checks++; if (npulse != 3 || pop_total != 6) begin n_fail++; $display("FAIL fault_pulses got %0d pulses %0d pop cycles want 3/6", npulse, pop_total); end
        n_checks++; if (starts[0] != 0 || starts[1] != 10 || starts[2] != 20) begin n_fail++; $display("FAIL fault_spacing got %0d,%0d,%0d want 0,10,20", starts[0], starts[1], starts[2]); end
        n_checks++; if (fault_at != 30) begin n_fail++; $display("FAIL fault_time got %0d want 30", fault_at); end
        n_checks++; if (hif.req_ready !== 1'b0 || hif.busy !== 1'b1 || hif.paid_coins !== 5'd0 || hif.stock_level !== 8'd252) begin n_fail++; $display("FAIL fault_state got ready=%0b busy=%0b paid=%0d stock=%0d want 0/1/0/252", hif.req_ready, hif.busy, hif.paid_coins, hif.stock_level); end
        any_pop = 1'b0;
        hif.req_valid = 1'b1;
        hif.req_coins = 5'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            if (hif.pop_100_yen_coin === 1'b1) any_pop = 1'b1;
        end
        hif.req_valid = 1'b0;
        hif.req_coins = '0;
        n_checks++; if (any_pop || hif.fault !== 1'b1 || hif.paid_coins !== 5'd0) begin n_fail++; $display("FAIL fault_sticky got pop_seen=%0b fault=%0b paid=%0d want 0/1/0", any_pop, hif.fault, hif.paid_coins); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        step();
        reset = 1'b1;
        request(5'd3);
        step();
        n_checks++; if (hif.pop_100_yen_coin !== 1'b1) begin n_fail++; $display("FAIL mid_pop got %0b want 1", hif.pop_100_yen_coin); end
        reset = 1'b0;
        step();
        n_checks++; if (hif.pop_100_yen_coin !== 1'b0 || hif.busy !== 1'b0) begin n_fail++; $display("FAIL mid_abort got pop=%0b busy=%0b want 0/0", hif.pop_100_yen_coin, hif.busy); end
        n_checks++; if (hif.stock_level !== 8'd50 || hif.req_ready !== 1'b1 || hif.fault !== 1'b0 || hif.paid_coins !== 5'd0) begin n_fail++; $display("FAIL mid_state got stock=%0d ready=%0b fault=%0b paid=%0d want 50/1/0/0", hif.stock_level, hif.req_ready, hif.fault, hif.paid_coins); end
        reset = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_zero();
        test_refill_with_sense();
        test_short();
        test_refill_sat();
        test_sense_in_eject();
        test_retry();
        test_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
